// File: rtl/dac_play_ctrl.sv
// dac_play_ctrl: playback sequencer for the I2S DAC serializer.
// Fetches one 16-bit sample per audio frame from sample memory over a
// req/ack handshake and presents it on `data` for both slots of the next
// frame. Handles start/pause/stop/end-of-buffer and variable speed:
// address skipping (fast) or sample repetition (slow).
//
// Ports:
//   clk_n      bit clock, all flops update on its falling edge
//   rst        asynchronous active-low reset
//   daclrc     DAC LR clock (async), rising edge marks a new frame
//   start/stop one-cycle control pulses; pause is a level
//   fast/speed playback mode and rate factor minus one
//   end_addr   last valid sample address (inclusive)
//   mem_*      sample memory fetch handshake
//   data       sample to serializer
//   busy/done/underrun status
//
// Optional build macro: PAUSE_MUTE_EN -- mute `data` while paused.
module dac_play_ctrl #(
  parameter int ADDR_W = 20
) (
  input  logic              clk_n,
  input  logic              rst,
  input  logic              daclrc,
  input  logic              start,
  input  logic              pause,
  input  logic              stop,
  input  logic              fast,
  input  logic [2:0]        speed,
  input  logic [ADDR_W-1:0] end_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  output logic [15:0]       data,
  output logic              busy,
  output logic              done,
  output logic              underrun
);

  typedef enum logic [2:0] {IDLE, PRIME, PLAY, PAUSED, DRAIN} state_t;

  state_t            state;
  logic              lrc_p0, lrc_p1, lrc_p2;
  logic              rise;
  logic [ADDR_W-1:0] addr;
  logic [2:0]        rep;
  logic              ending;
  logic [15:0]       next_smp;

  logic              pending;
  logic [15:0]       cur_smp;
  logic              adv_fetch;
  logic [ADDR_W:0]   step_addr;
  logic              past_end;

  // daclrc synchronizer + edge register
  always_ff @(negedge clk_n or negedge rst) begin
    if (!rst) begin
      lrc_p0 <= 1'b0;
      lrc_p1 <= 1'b0;
      lrc_p2 <= 1'b0;
    end else begin
      lrc_p0 <= daclrc;
      lrc_p1 <= lrc_p0;
      lrc_p2 <= lrc_p1;
    end
  end

  assign rise = lrc_p1 & ~lrc_p2;

  // A fetch acked in the rise cycle itself is on time: play the bus value.
  assign pending = mem_req & ~mem_ack;
  assign cur_smp = mem_ack ? mem_rdata : next_smp;
  assign busy    = (state != IDLE);

  // One extra bit so that stepping past the top of memory compares correctly.
  always_comb begin
    adv_fetch = 1'b1;
    step_addr = {1'b0, addr} + (ADDR_W+1)'(speed) + (ADDR_W+1)'(1);
    if (!fast) begin
      adv_fetch = (rep == speed);
      step_addr = {1'b0, addr} + (ADDR_W+1)'(1);
    end
  end

  assign past_end = step_addr > {1'b0, end_addr};

  always_ff @(negedge clk_n or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      addr     <= '0;
      rep      <= '0;
      ending   <= 1'b0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      data     <= '0;
      done     <= 1'b0;
      underrun <= 1'b0;
    end else begin
      done <= 1'b0;
      // Request drops after ack unless a new fetch is issued below.
      if (mem_ack) mem_req <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            underrun <= 1'b0;
            addr     <= '0;
            rep      <= '0;
            ending   <= 1'b0;
            mem_req  <= 1'b1;
            mem_addr <= '0;
            state    <= PRIME;
          end
        end
        PRIME, PLAY, PAUSED: begin
          if (stop) begin
            // An outstanding fetch must finish before the bus is released.
            state  <= pending ? DRAIN : IDLE;
            data   <= '0;
            ending <= 1'b0;
          end else if (state == PRIME) begin
            if (mem_ack) state <= PLAY;
          end else if (rise) begin
            if (ending) begin
              state  <= IDLE;
              done   <= 1'b1;
              data   <= '0;
              ending <= 1'b0;
            end else if (pause) begin
              if (state == PLAY) begin
                state <= PAUSED;
`ifdef PAUSE_MUTE_EN
                data  <= '0;
`endif
              end
            end else if (pending) begin
              // Late sample: hold data and the request, retry next frame.
              state    <= PLAY;
              underrun <= 1'b1;
            end else begin
              state <= PLAY;
              data  <= cur_smp;
              if (!fast) rep <= adv_fetch ? 3'd0 : rep + 3'd1;
              if (adv_fetch) begin
                if (past_end) begin
                  ending <= 1'b1;
                end else begin
                  addr     <= step_addr[ADDR_W-1:0];
                  mem_addr <= step_addr[ADDR_W-1:0];
                  mem_req  <= 1'b1;
                end
              end
            end
          end
        end
        DRAIN: begin
          if (mem_ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sample holding register; drained data is discarded.
  always_ff @(negedge clk_n) begin
    if (mem_ack && state != DRAIN && state != IDLE) next_smp <= mem_rdata;
  end

endmodule

// File: tb/tb_dac_play_ctrl.sv
// Testbench for dac_play_ctrl: frame-level reference model of playback
// (expected per-frame sample list and fetch address list) driven by
// randomized and directed runs against a latency-programmable memory.
module tb_dac_play_ctrl;
  localparam int ADDR_W = 20;

  logic              clk_n = 1'b0;
  logic              rst = 1'b0;
  logic              daclrc = 1'b0;
  logic              start = 1'b0;
  logic              pause = 1'b0;
  logic              stop = 1'b0;
  logic              fast = 1'b0;
  logic [2:0]        speed = 3'd0;
  logic [ADDR_W-1:0] end_addr = '0;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack = 1'b0;
  logic [15:0]       mem_rdata = 16'h0;
  logic [15:0]       data;
  logic              busy;
  logic              done;
  logic              underrun;

  int n_chk = 0;
  int n_err = 0;
  int done_cnt = 0;
  logic [15:0] mem [64];
  int base_lat = 2;
  int late_idx = 0;
  int late_lat = 30;
  int nfetch = 0;
  int cnt = 0;
  int fetch_log[$];

  dac_play_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk_n(clk_n), .rst(rst), .daclrc(daclrc), .start(start), .pause(pause),
    .stop(stop), .fast(fast), .speed(speed), .end_addr(end_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .data(data), .busy(busy), .done(done),
    .underrun(underrun)
  );

  always #5 clk_n = ~clk_n;

  // Frame clock: 24 bit-clock cycles per frame.
  initial forever begin
    repeat (12) @(posedge clk_n);
    daclrc = ~daclrc;
  end

  // Memory responder: ack after a programmable latency, log fetched address.
  initial forever begin
    @(posedge clk_n);
    if (!rst) begin
      mem_ack = 1'b0;
      cnt = 0;
    end else if (mem_ack) begin
      mem_ack = 1'b0;
    end else if (mem_req) begin
      if (cnt >= ((late_idx > 0 && nfetch == late_idx) ? late_lat : base_lat)) begin
        mem_ack = 1'b1;
        mem_rdata = mem[mem_addr[5:0]];
        fetch_log.push_back(int'(mem_addr));
        nfetch++;
        cnt = 0;
      end else begin
        cnt++;
      end
    end
  end

  initial forever begin
    @(posedge clk_n);
    if (done) done_cnt++;
  end

  initial begin
    #800000;
    $display("FAIL timeout n_chk=%0d", n_chk);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_start();
    @(negedge daclrc);
    @(posedge clk_n);
    fetch_log.delete();
    nfetch = 0;
    start = 1'b1;
    @(posedge clk_n);
    start = 1'b0;
    #1;
    chk("underrun_clr", underrun, 0);
  endtask

  task automatic run_play(input bit f, input int sp, input int ea, input int lat,
                          input int late_n, input int pause_k);
    int addrs[$];
    int fexp[$];
    logic [15:0] exp_q[$];
    int done0;
    int nmin;
    fast = f;
    speed = sp[2:0];
    end_addr = ADDR_W'(ea);
    base_lat = lat;
    late_idx = late_n;
    if (f) begin
      for (int a = 0; a <= ea; a += sp + 1) begin
        addrs.push_back(a);
        fexp.push_back(a);
      end
    end else begin
      for (int a = 0; a <= ea; a++) begin
        fexp.push_back(a);
        for (int r = 0; r <= sp; r++) addrs.push_back(a);
      end
    end
    for (int i = 0; i < addrs.size(); i++) begin
      if (late_n > 0 && i == late_n) exp_q.push_back(mem[addrs[i-1]]);
      exp_q.push_back(mem[addrs[i]]);
      if (i == pause_k) begin
        for (int r = 0; r < 4; r++) begin
`ifdef PAUSE_MUTE_EN
          exp_q.push_back(16'h0);
`else
          exp_q.push_back(mem[addrs[i]]);
`endif
        end
      end
    end
    done0 = done_cnt;
    do_start();
    for (int j = 0; j < exp_q.size(); j++) begin
      @(negedge daclrc);
      #1;
      chk($sformatf("data[%0d]", j), data, exp_q[j]);
      if (pause_k >= 0 && j == pause_k) pause = 1'b1;
      if (pause_k >= 0 && j == pause_k + 4) pause = 1'b0;
    end
    @(negedge daclrc);
    #1;
    chk("end_data", data, 0);
    chk("end_busy", busy, 0);
    chk("done_cnt", done_cnt - done0, 1);
    chk("underrun", underrun, (late_n > 0) ? 1 : 0);
    chk("nfetch", fetch_log.size(), fexp.size());
    nmin = (fetch_log.size() < fexp.size()) ? fetch_log.size() : fexp.size();
    for (int i = 0; i < nmin; i++) chk($sformatf("faddr[%0d]", i), fetch_log[i], fexp[i]);
    late_idx = 0;
  endtask

  // Start a 1x run whose third fetch is late, stopping after frame 1.
  task automatic start_late_run();
    fast = 1'b1;
    speed = 3'd0;
    end_addr = ADDR_W'(20);
    base_lat = 2;
    late_idx = 2;
    do_start();
    @(negedge daclrc);
    #1;
    chk("lr_data0", data, mem[0]);
    @(negedge daclrc);
    #1;
    chk("lr_data1", data, mem[1]);
    chk("lr_req", mem_req, 1);
    chk("lr_addr", mem_addr, 2);
  endtask

  initial begin
    int done0;
    int k;
    for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;

    repeat (3) @(posedge clk_n);
    #1;
    chk("rst_data", data, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_underrun", underrun, 0);
    #1 rst = 1'b1;

    run_play(1, 0, 3, 2, 0, -1);   // 1x
    run_play(1, 2, 9, 2, 0, -1);   // fast 3x: 0,3,6,9
    run_play(0, 2, 3, 1, 0, -1);   // slow 3x
    run_play(1, 0, 5, 2, 2, -1);   // late ack -> underrun
    run_play(1, 0, 7, 2, 0, 2);    // pause 4 frames
    run_play(0, 1, 3, 2, 0, 3);    // pause in slow mode

    // Stop with a fetch outstanding -> DRAIN until ack, no done.
    done0 = done_cnt;
    start_late_run();
    @(posedge clk_n);
    stop = 1'b1;
    @(posedge clk_n);
    stop = 1'b0;
    #1;
    chk("drain_busy", busy, 1);
    chk("drain_req", mem_req, 1);
    chk("drain_data", data, 0);
    k = 0;
    while (!mem_ack && k < 60) begin
      @(posedge clk_n);
      #1;
      k++;
    end
    chk("drain_ack_seen", mem_ack, 1);
    @(posedge clk_n);
    #1;
    chk("stop_busy", busy, 0);
    chk("stop_req", mem_req, 0);
    chk("stop_data", data, 0);
    chk("stop_nodone", done_cnt - done0, 0);
    late_idx = 0;

    // Stop and pause together in a rise cycle: stop wins.
    fast = 1'b1;
    speed = 3'd0;
    end_addr = ADDR_W'(20);
    base_lat = 2;
    done0 = done_cnt;
    do_start();
    @(negedge daclrc);
    #1;
    chk("sp_data0", data, mem[0]);
    @(posedge daclrc);
    repeat (2) @(posedge clk_n);
    stop = 1'b1;
    pause = 1'b1;
    @(posedge clk_n);
    stop = 1'b0;
    pause = 1'b0;
    #1;
    chk("sp_busy", busy, 0);
    chk("sp_data", data, 0);
    chk("sp_req", mem_req, 0);
    chk("sp_nodone", done_cnt - done0, 0);

    // Asynchronous reset mid-fetch.
    start_late_run();
    @(posedge clk_n);
    #2 rst = 1'b0;
    #1;
    chk("ar_req", mem_req, 0);
    chk("ar_addr", mem_addr, 0);
    chk("ar_data", data, 0);
    chk("ar_busy", busy, 0);
    chk("ar_done", done, 0);
    chk("ar_underrun", underrun, 0);
    @(posedge clk_n);
    #2 rst = 1'b1;
    late_idx = 0;

    // Randomized runs.
    for (int t = 0; t < 6; t++) begin
      bit f;
      int sp, ea, lat, len, late_n, pause_k;
      for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
      f = 1'($urandom_range(0, 1));
      sp = $urandom_range(0, 7);
      ea = $urandom_range(0, 10);
      lat = $urandom_range(0, 5);
      len = f ? (ea / (sp + 1) + 1) : (ea + 1) * (sp + 1);
      late_n = 0;
      pause_k = -1;
      if ($urandom_range(0, 1) == 1) begin
        if (f && len >= 2) late_n = $urandom_range(1, len - 1);
      end else if (len >= 2) begin
        pause_k = $urandom_range(0, len - 2);
      end
      run_play(f, sp, ea, lat, late_n, pause_k);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/dac_play_ctrl.md
# dac_play_ctrl

Playback sequencer that feeds the I2S DAC serializer's 16-bit `data` input from sample memory. It performs one memory fetch per audio frame over a req/ack handshake and sequences start, pause, stop and end-of-buffer. It applies variable playback speed: address skipping for fast playback, sample repetition for slow playback. It sits between the SRAM arbiter port and the DAC serializer and is clocked by the same `clk_n`.

## Interface
- `ADDR_W`, 20, sample memory address width (16-bit words)
- `clk_n`  in  1  bit clock; all flops update on falling edge of `clk_n`
- `rst`  in  1  reset, asynchronous, active-low
- `daclrc`  in  1  DAC LR clock, asynchronous to flop timing; 0 = left slot, 1 = right slot
- `start`  in  1  one-cycle pulse; begin playback at address 0
- `pause`  in  1  level; freeze playback while high
- `stop`  in  1  one-cycle pulse; abort playback
- `fast`  in  1  1 = fast (skip), 0 = slow (repeat)
- `speed`  in  3  rate factor minus one (0..7 → 1x..8x)
- `end_addr`  in  ADDR_W  last valid sample address, inclusive
- `mem_req`  out  1  fetch request
- `mem_addr`  out  ADDR_W  fetch address, stable while `mem_req`=1
- `mem_ack`  in  1  fetch complete; `mem_rdata` valid in this cycle
- `mem_rdata`  in  16  fetched sample
- `data`  out  16  sample to DAC serializer (same sample in both slots)
- `busy`  out  1  high in any state except IDLE
- `done`  out  1  one-cycle pulse at natural end of buffer
- `underrun`  out  1  sticky; cleared by `start`

## Operation
- `daclrc` is passed through a 2-flop synchronizer plus an edge register. A rising edge is detected (`rise`) 3 cycles after the pin edge.
- States: IDLE, PRIME, PLAY, PAUSED, DRAIN.
- IDLE:
  - `data`=0, `mem_req`=0.
  - `start` clears `underrun`, sets `addr`=0 and `rep`=0, issues a fetch of address 0, then goes to PRIME.
- PRIME: on `mem_ack`, latch `mem_rdata` into `next_smp`, then go to PLAY.
- PLAY, on each `rise`:
  - `data` ← `next_smp`.
  - Compute the next address, then issue a fetch for it.
  - Fast mode: `addr` ← `addr`+`speed`+1.
  - Slow mode: if `rep`==`speed`, then `rep`←0 and `addr`←`addr`+1. Otherwise `rep`←`rep`+1, no fetch, and `next_smp` is reused.
  - Address arithmetic is ADDR_W+1 bits wide.
  - If the new address > `end_addr`, no fetch is issued; go to IDLE at the next `rise`, pulse `done`, and set `data`←0.
- Underrun: if `rise` occurs while a fetch is outstanding:
  - Set `underrun`.
  - Hold `data` at its previous value.
  - Keep the request; the next `rise` consumes the late sample.
- `pause`=1 in PLAY moves to PAUSED at the next `rise`. An outstanding fetch still completes.
- PAUSED:
  - `data` is held.
  - `pause`=0 returns to PLAY at the next `rise`.
- `stop` in any non-IDLE state:
  - If no fetch is outstanding, go to IDLE next cycle.
  - Otherwise go to DRAIN, keep `mem_req` until `mem_ack`, discard the data, then go to IDLE.
  - No `done` pulse on stop.
- Priority within one cycle: `stop` > end-of-buffer > `pause`. `start` is ignored unless IDLE.
- `fast`, `speed` and `end_addr` are sampled only at `rise` and `start`.

## Timing
- Reset values: `data`=0, `mem_req`=0, `mem_addr`=0, `busy`=0, `done`=0, `underrun`=0; state IDLE; synchronizer flops 0.
- `mem_req` rises 1 cycle after the triggering `rise`/`start`. It drops in the cycle after `mem_ack`.
- `data` changes only in the `rise` cycle. This is 3 cycles after the pin rising edge, after the serializer has captured the right-slot word, so left and right slots of the next frame carry the same sample.
- Playback latency: first sample appears on `data` at the first `rise` after PRIME completes.
- `done` is asserted in the same cycle `busy` falls.
- An asynchronous reset mid-handshake drops `mem_req` immediately; the memory side must tolerate this.

## Configuration
- `PAUSE_MUTE_EN`: when defined, `data` is forced to 0 in the `rise` cycle entering PAUSED and restored from `next_smp` on the `rise` leaving PAUSED.
- When `PAUSE_MUTE_EN` is undefined, `data` holds the last played sample during pause.

## Test plan
- Normal 1x playback: reset, `fast`=1, `speed`=0, `end_addr`=3, memory holds 0x1111..0x4444, ack after 2 cycles. `data` steps 0x1111→0x4444 on successive `rise`. Next `rise` gives `data`=0 and `done` pulse. `underrun`=0.
- Fast 3x playback: `fast`=1, `speed`=2, `end_addr`=9 → fetched addresses 0,3,6,9, then `done`.
- Slow 3x playback: `fast`=0, `speed`=2 → each sample is held for 3 frames and only 1 fetch is issued per 3 `rise`.
- Late ack: ack withheld past the next `rise` → `underrun`=1, `data` unchanged that frame, late sample appears at the following `rise`. A subsequent `start` clears `underrun`.
- Stop while `mem_req`=1 → enters DRAIN, `mem_req` holds until `mem_ack`, then IDLE with `busy`=0, no `done` pulse, `data`=0.
- Pause for 4 frames, stop and pause asserted together, and reset asserted mid-fetch:
  - Pause: `data` frozen, or 0 with `PAUSE_MUTE_EN`; resume continues at the correct address.
  - `stop` and `pause` together: `stop` wins.
  - Reset mid-fetch: all outputs are at reset values immediately.
